// File: rtl/alu_seq_md.sv
// Registered ALU with an iterative RV32M multiply/divide unit behind a
// start/busy/done handshake. Base ops finish in one cycle; MUL*/DIV*/REM*
// take WIDTH cycles (radix-2 shift-add and restoring division).
// Optional feature macro: ALU_SEQ_MD_MULDIV_EN. When undefined, codes 1_0xxx
// behave as undefined codes (result 0, latency 1) and busy stays low.
module alu_seq_md #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       ALU_control,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALU_result,
  output logic             zero
);
  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [4:0] OpAdd  = 5'b00000;
  localparam logic [4:0] OpSub  = 5'b00001;
  localparam logic [4:0] OpAnd  = 5'b00010;
  localparam logic [4:0] OpOr   = 5'b00011;
  localparam logic [4:0] OpXor  = 5'b00100;
  localparam logic [4:0] OpSll  = 5'b00101;
  localparam logic [4:0] OpSrl  = 5'b00110;
  localparam logic [4:0] OpSra  = 5'b00111;
  localparam logic [4:0] OpSltu = 5'b01000;
  localparam logic [4:0] OpSlt  = 5'b01001;

  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] base_res;

  assign shamt = B[SHW-1:0];

  // Single-cycle base operations, computed straight from the inputs.
  always_comb begin
    base_res = '0;
    case (ALU_control)
      OpAdd:   base_res = A + B;
      OpSub:   base_res = A - B;
      OpAnd:   base_res = A & B;
      OpOr:    base_res = A | B;
      OpXor:   base_res = A ^ B;
      OpSll:   base_res = A << shamt;
      OpSrl:   base_res = A >> shamt;
      OpSra:   base_res = $signed(A) >>> shamt;
      OpSltu:  base_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OpSlt:   base_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: base_res = '0;
    endcase
  end

`ifdef ALU_SEQ_MD_MULDIV_EN
  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e           state_q;
  logic             busy_q;
  logic [WIDTH-1:0] acc_q;   // mul: high half of product; div: partial remainder
  logic [WIDTH-1:0] lo_q;    // mul: low half / multiplier; div: dividend -> quotient
  logic [WIDTH-1:0] opb_q;   // mul: multiplicand; div: divisor (magnitudes)
  logic [SHW-1:0]   cnt_q;
  logic             neg_q;   // negate the final magnitude
  logic             sel_q;   // mul: take low half; div: take remainder

  logic             is_mul, is_div, sgn_a, sgn_b, a_neg, b_neg, fast_div;
  logic [WIDTH-1:0] a_mag, b_mag, fast_res, imm_res;

  // Operand decode at start: signedness, magnitudes and the division fast-path.
  always_comb begin
    is_mul = (ALU_control[4:2] == 3'b100);
    is_div = (ALU_control[4:2] == 3'b101);
    if (ALU_control[2]) begin
      sgn_a = ~ALU_control[0];
      sgn_b = ~ALU_control[0];
    end else begin
      sgn_a = ALU_control[1] ^ ALU_control[0];  // MULH, MULHSU
      sgn_b = (ALU_control[1:0] == 2'b01);      // MULH
    end
    a_neg    = sgn_a & A[WIDTH-1];
    b_neg    = sgn_b & B[WIDTH-1];
    a_mag    = a_neg ? -A : A;
    b_mag    = b_neg ? -B : B;
    fast_div = is_div & ((B == '0) |
               (sgn_b & (A == {1'b1, {(WIDTH-1){1'b0}}}) & (B == '1)));
    if (B == '0) fast_res = ALU_control[1] ? A : '1;
    else         fast_res = ALU_control[1] ? '0 : A;
    imm_res  = is_div ? fast_res : base_res;
  end

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_acc_n, mul_lo_n, mul_res;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic               ge;
  logic [WIDTH-1:0]   div_acc_n, div_lo_n, div_pick, div_res;

  // One iteration of each datapath plus the final sign fix-up.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    mul_acc_n = mul_sum[WIDTH:1];
    mul_lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};
    prod      = {mul_acc_n, mul_lo_n};
    prod_s    = neg_q ? -prod : prod;
    mul_res   = sel_q ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];

    rem_sh    = {acc_q, lo_q[WIDTH-1]};
    rem_diff  = rem_sh - {1'b0, opb_q};
    ge        = ~rem_diff[WIDTH];
    div_acc_n = ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    div_lo_n  = {lo_q[WIDTH-2:0], ge};
    div_pick  = sel_q ? div_acc_n : div_lo_n;
    div_res   = neg_q ? -div_pick : div_pick;
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= StIdle;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      acc_q    <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      sel_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (is_mul || (is_div && !fast_div)) begin
              state_q <= is_mul ? StMul : StDiv;
              busy_q  <= 1'b1;
              acc_q   <= '0;
              lo_q    <= a_mag;
              opb_q   <= b_mag;
              cnt_q   <= '0;
              if (is_mul) begin
                neg_q <= a_neg ^ b_neg;
                sel_q <= (ALU_control[1:0] == 2'b00);
              end else begin
                neg_q <= ALU_control[1] ? a_neg : (a_neg ^ b_neg);
                sel_q <= ALU_control[1];
              end
            end else begin
              result_q <= imm_res;
              zero_q   <= (imm_res == '0);
              done_q   <= 1'b1;
            end
          end
        end
        StMul, StDiv: begin
          acc_q <= (state_q == StMul) ? mul_acc_n : div_acc_n;
          lo_q  <= (state_q == StMul) ? mul_lo_n : div_lo_n;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == SHW'(WIDTH-1)) begin
            result_q <= (state_q == StMul) ? mul_res : div_res;
            zero_q   <= (((state_q == StMul) ? mul_res : div_res) == '0);
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
`else
  // Every accepted op completes in one cycle; M-extension codes decode to 0.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        result_q <= base_res;
        zero_q   <= (base_res == '0);
        done_q   <= 1'b1;
      end
    end
  end

  assign busy = 1'b0;
`endif

  assign done       = done_q;
  assign ALU_result = result_q;
  assign zero       = zero_q;
endmodule

// File: doc/alu_seq_md.md
Name: alu_seq_md

Overview:
Parametrised, registered successor of the core ALU. It adds the RV32M multiply/divide operations, computed iteratively one bit per cycle. It is driven by a start/busy/done handshake so the control unit can stall the pipeline on long operations. Base ops complete in 1 cycle; MUL*/DIV*/REM* take WIDTH cycles.

Parameters:
WIDTH, 32, operand/result width (power of 2, >=8); localparam SHW = $clog2(WIDTH) = shift-amount width

Ports:
CLOCK  input  1  system clock, rising edge
RESET_N  input  1  asynchronous, active-low reset
start  input  1  request; sampled only when busy=0
A  input  WIDTH  operand A (rs1)
B  input  WIDTH  operand B (rs2/imm)
ALU_control  input  5  operation code
busy  output  1  high while an iterative op is in flight
done  output  1  one-cycle pulse: ALU_result/zero valid
ALU_result  output  WIDTH  registered result, held until next done
zero  output  1  registered, 1 iff ALU_result==0

Behaviour:
- Reset (RESET_N low, async, any state): state=IDLE, busy=0, done=0, ALU_result=0, zero=1, counter and internal registers cleared. An in-flight op is discarded with no done pulse.
- Opcodes 0_0000..0_1001: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLTU, SLT.
- Opcodes 1_0000..1_0111: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Any other code: result 0, latency 1.
- Shifts use B[SHW-1:0] only; SRA sign-fills. SLT/SLTU return 1 or 0, zero-extended. ADD/SUB wrap modulo 2^WIDTH.
- FSM states: IDLE, MUL, DIV.
- IDLE: on edge N with start=1, latch A, B, ALU_control.
  - Base/undefined op or div fast-path: ALU_result and zero load at edge N, done=1 for the following cycle, state stays IDLE, busy stays 0.
  - Mul op: go to MUL, busy=1 from edge N.
  - Div op: go to DIV, busy=1 from edge N.
- MUL: radix-2 shift-add on |A|, |B|.
  - Signedness per op: MULH signed x signed; MULHSU signed A, unsigned B; MULHU and MUL unsigned.
  - Steps at edges N+1..N+WIDTH; product negated at the end if the operand signs differ.
  - Result is the low WIDTH bits for MUL, high WIDTH bits otherwise.
- DIV: restoring division, one quotient bit per edge N+1..N+WIDTH, on magnitudes for DIV/REM.
  - Quotient is negative if the operand signs differ; remainder takes the dividend's sign.
- Completion of MUL/DIV: at edge N+WIDTH, load the result, busy=0, done=1 for one cycle, state=IDLE.
- Div fast-path (latency 1, no DIV state):
  - B==0: DIV/DIVU give all-ones; REM/REMU give A.
  - DIV/REM with A=most-negative and B=-1: DIV gives A; REM gives 0.
- start while busy=1 is ignored. Operand/control changes while busy are ignored.
- start may be asserted in the done cycle (busy=0) and is accepted, so back-to-back ops are allowed.
- done never asserts without a prior accepted start. ALU_result is unchanged except at a done load.

Optional Feature:
ALU_SEQ_MD_MULDIV_EN
- Defined: MUL and DIV states and datapath are present, as described above.
- Undefined: no iterative hardware. Codes 1_0xxx behave as undefined codes: result 0, zero=1, latency 1, busy always 0.

Test Plan:
- ADD A=5 B=7 -> done the cycle after start, ALU_result=12, zero=0. SUB A=7 B=7 -> 0, zero=1. SRA A=0x80000000 B=0x24 -> 0xF8000000 (shift 4).
- A=B=0xFFFFFFFF -> MUL=0x00000001, MULHU=0xFFFFFFFE, MULH=0x00000000, MULHSU=0xFFFFFFFF. busy high exactly 32 cycles, then a single done pulse.
- DIV A=-20 B=3 -> 0xFFFFFFFA, REM -> 0xFFFFFFFE. DIVU A=100 B=7 -> 14, REMU -> 2. Each has 32-cycle latency.
- DIV A=42 B=0 -> 0xFFFFFFFF, REM -> 42, DIVU -> 0xFFFFFFFF. DIV A=0x80000000 B=0xFFFFFFFF -> 0x80000000, REM -> 0. All complete in 1 cycle with busy=0.
- Start DIVU 100/7, re-pulse start with A=1 B=1 at cycle 5 -> ignored, result still 14. Start DIV, assert RESET_N=0 at cycle 10 -> busy=0, done=0, ALU_result=0, zero=1 immediately. After release, ADD 1+1 -> 2.
- Build without ALU_SEQ_MD_MULDIV_EN: MUL A=3 B=4 -> ALU_result=0, zero=1, done 1 cycle after start, busy never 1.
